// File: rtl/mem_copy_initiator.sv
// Block copy / fill initiator driving a multicycle single-byte memory request port.
// One FSM issues read/write request pairs (copy) or writes (fill) with a per-request response timeout.
module mem_copy_initiator #(
    parameter int AW      = 8,
    parameter int DW      = 8,
    parameter int TIMEOUT = 15
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          go,
    input  logic          mode,
    input  logic [AW-1:0] src_base,
    input  logic [AW-1:0] dst_base,
    input  logic [AW-1:0] length,
    input  logic [DW-1:0] fill_data,
    output logic          busy,
    output logic          finished,
    output logic          error,
    output logic [AW-1:0] count,
    output logic          mem_start,
    output logic [1:0]    mem_op,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic          mem_done,
    input  logic [DW-1:0] mem_rdata
);

    typedef enum logic [2:0] {
        IDLE, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT, STEP, FINISH, ABORT
    } state_t;

    localparam logic [1:0] OP_WR = 2'b00;
    localparam logic [1:0] OP_RD = 2'b01;
    localparam logic [7:0] TO    = 8'(TIMEOUT);

    state_t        state_q;
    logic          mode_q;
    logic [AW-1:0] src_q, dst_q, rem_q, count_q, mem_addr_q;
    logic [DW-1:0] fill_q, data_q, mem_wdata_q;
    logic [7:0]    timer_q, timer_d;
    logic          finished_q, error_q, mem_start_q;
    logic [1:0]    mem_op_q;

    assign timer_d = timer_q + 8'd1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            mode_q      <= 1'b0;
            src_q       <= '0;
            dst_q       <= '0;
            rem_q       <= '0;
            count_q     <= '0;
            fill_q      <= '0;
            data_q      <= '0;
            timer_q     <= '0;
            finished_q  <= 1'b0;
            error_q     <= 1'b0;
            mem_start_q <= 1'b0;
            mem_op_q    <= OP_WR;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            // Pulse outputs default low; only REQ/FINISH/ABORT raise them for one cycle.
            mem_start_q <= 1'b0;
            finished_q  <= 1'b0;
            error_q     <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (go) begin
                        mode_q  <= mode;
                        src_q   <= src_base;
                        dst_q   <= dst_base;
                        rem_q   <= length;
                        fill_q  <= fill_data;
                        count_q <= '0;
                        if (length == '0)  state_q <= FINISH;
                        else if (mode)     state_q <= WR_REQ;
                        else               state_q <= RD_REQ;
                    end
                end
                RD_REQ: begin
                    mem_start_q <= 1'b1;
                    mem_op_q    <= OP_RD;
                    mem_addr_q  <= src_q;
                    timer_q     <= '0;
                    state_q     <= RD_WAIT;
                end
                RD_WAIT: begin
                    if (mem_done) begin
                        data_q  <= mem_rdata;
                        state_q <= WR_REQ;
                    end else begin
                        timer_q <= timer_d;
                        if (timer_d == TO) state_q <= ABORT;
                    end
                end
                WR_REQ: begin
                    mem_start_q <= 1'b1;
                    mem_op_q    <= OP_WR;
                    mem_addr_q  <= dst_q;
                    mem_wdata_q <= mode_q ? fill_q : data_q;
                    timer_q     <= '0;
                    state_q     <= WR_WAIT;
                end
                WR_WAIT: begin
                    if (mem_done) begin
                        count_q <= count_q + AW'(1);
                        state_q <= STEP;
                    end else begin
                        timer_q <= timer_d;
                        if (timer_d == TO) state_q <= ABORT;
                    end
                end
                STEP: begin
                    src_q <= src_q + AW'(1);
                    dst_q <= dst_q + AW'(1);
                    rem_q <= rem_q - AW'(1);
                    if (rem_q == AW'(1)) state_q <= FINISH;
                    else if (mode_q)     state_q <= WR_REQ;
                    else                 state_q <= RD_REQ;
                end
                FINISH: begin
                    finished_q <= 1'b1;
                    state_q    <= IDLE;
                end
                ABORT: begin
                    error_q <= 1'b1;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy      = (state_q != IDLE);
    assign finished  = finished_q;
    assign error     = error_q;
    assign count     = count_q;
    assign mem_start = mem_start_q;
    assign mem_op    = mem_op_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_copy_initiator.sv
// Self-checking bench: directed command table plus random commands against a byte-level copy/fill model,
// with a latency-programmable memory stub and a mid-transfer reset sequence.
module tb_mem_copy_initiator;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       go = 1'b0;
    logic       mode = 1'b0;
    logic [7:0] src_base = '0, dst_base = '0, length = '0, fill_data = '0;
    logic       busy, finished, error, mem_start;
    logic [7:0] count, mem_addr, mem_wdata;
    logic [1:0] mem_op;
    logic       mem_done = 1'b0;
    logic [7:0] mem_rdata = '0;

    mem_copy_initiator #(.AW(8), .DW(8), .TIMEOUT(15)) dut (
        .clk(clk), .rst(rst), .go(go), .mode(mode),
        .src_base(src_base), .dst_base(dst_base), .length(length), .fill_data(fill_data),
        .busy(busy), .finished(finished), .error(error), .count(count),
        .mem_start(mem_start), .mem_op(mem_op), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_done(mem_done), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0] op;
        logic [7:0] addr;
        logic [7:0] data;
    } req_t;

    typedef struct {
        logic       mode;
        logic [7:0] src, dst, len, fill;
        int         lat;
        bit         hang;
        int         exp_count;
        int         exp_delay;   // -1: not checked
    } vec_t;

    logic [7:0] mem     [256];
    logic [7:0] ref_mem [256];
    req_t       log_q[$];
    req_t       exp_q[$];
    req_t       cur;
    int         lat = 1;
    bit         hang = 1'b0;
    bit         pend = 1'b0;
    int         pcnt = 0;
    bit         prev_start = 1'b0;
    int         fin_cnt = 0, err_cnt = 0;
    int         viol_b2b = 0, viol_op = 0, viol_hold = 0;
    int         n_tests = 0, n_fail = 0;

    // Memory stub: records every request, answers after 'lat' cycles unless hung.
    always @(negedge clk) begin
        if (mem_done) mem_done = 1'b0;
        if (finished) fin_cnt++;
        if (error) err_cnt++;
        if (pend) begin
            if (busy && (mem_addr !== cur.addr || (cur.op == 2'b00 && mem_wdata !== cur.data)))
                viol_hold++;
            pcnt--;
            if (pcnt == 0) begin
                pend = 1'b0;
                mem_done = 1'b1;
                if (cur.op == 2'b01) mem_rdata = mem[cur.addr];
                else                 mem[cur.addr] = cur.data;
            end
        end
        if (mem_start) begin
            if (prev_start) viol_b2b++;
            if (mem_op[1]) viol_op++;
            cur = '{op: mem_op, addr: mem_addr, data: mem_wdata};
            log_q.push_back(cur);
            if (!hang) begin
                pend = 1'b1;
                pcnt = lat;
            end
        end
        prev_start = mem_start;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: bytes move one at a time in ascending order; a hung memory stops after the first request.
    task automatic model(input logic m, input logic [7:0] s, input logic [7:0] d,
                         input logic [7:0] n, input logic [7:0] f, input bit h);
        logic [7:0] sa, da, v;
        exp_q.delete();
        for (int i = 0; i < int'(n); i++) begin
            sa = s + 8'(i);
            da = d + 8'(i);
            if (!m) begin
                exp_q.push_back('{op: 2'b01, addr: sa, data: 8'h00});
                if (h) return;
                v = ref_mem[sa];
            end else begin
                v = f;
            end
            exp_q.push_back('{op: 2'b00, addr: da, data: v});
            if (h) return;
            ref_mem[da] = v;
        end
    endtask

    task automatic run_cmd(input string tag, input logic m, input logic [7:0] s, input logic [7:0] d,
                           input logic [7:0] n, input logic [7:0] f, input int l, input bit h,
                           input int exp_count, input int exp_delay);
        int  delay, bad;
        bit  exp_err;
        logic b1;
        exp_err = h && (n != 8'd0);
        for (int i = 0; i < 256; i++) ref_mem[i] = mem[i];
        model(m, s, d, n, f, h);
        @(negedge clk);
        lat = l; hang = h; log_q.delete(); fin_cnt = 0; err_cnt = 0;
        mode = m; src_base = s; dst_base = d; length = n; fill_data = f; go = 1'b1;
        @(negedge clk);
        b1 = busy;
        go = 1'b0;
        delay = 1;
        while (!(finished || error) && delay < 3000) begin
            @(negedge clk);
            delay++;
        end
        check({tag, " no_hang"}, (delay < 3000) ? 1 : 0, 1);
        repeat (3) @(negedge clk);
        hang = 1'b0;
        check({tag, " busy_start"}, b1, 1);
        check({tag, " busy_end"}, busy, 0);
        check({tag, " count"}, count, exp_count);
        check({tag, " fin_pulses"}, fin_cnt, exp_err ? 0 : 1);
        check({tag, " err_pulses"}, err_cnt, exp_err ? 1 : 0);
        if (exp_delay >= 0) check({tag, " delay"}, delay, exp_delay);
        check({tag, " nreq"}, log_q.size(), exp_q.size());
        bad = 0;
        for (int i = 0; i < exp_q.size() && i < log_q.size(); i++)
            if (log_q[i].op !== exp_q[i].op || log_q[i].addr !== exp_q[i].addr ||
                (exp_q[i].op == 2'b00 && log_q[i].data !== exp_q[i].data)) bad++;
        check({tag, " req_seq_bad"}, bad, 0);
        bad = 0;
        for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) bad++;
        check({tag, " mem_bad"}, bad, 0);
    endtask

    vec_t vecs[6];

    initial begin
        int         w;
        logic [7:0] saved;
        logic       rm;
        logic [7:0] rs, rd, rn, rf;
        int         rl;
        bit         rh;

        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
        mem[8'h20] = 8'h11; mem[8'h21] = 8'h22; mem[8'h22] = 8'h33;

        vecs[0] = '{1'b1, 8'h00, 8'h10, 8'd4, 8'hA5, 2, 1'b0, 4, -1};
        vecs[1] = '{1'b0, 8'h20, 8'h40, 8'd3, 8'h00, 1, 1'b0, 3, -1};
        vecs[2] = '{1'b0, 8'hFE, 8'hFF, 8'd3, 8'h00, 3, 1'b0, 3, -1};
        vecs[3] = '{1'b0, 8'h30, 8'h31, 8'd0, 8'h00, 1, 1'b0, 0, 2};
        vecs[4] = '{1'b0, 8'h60, 8'h90, 8'd5, 8'h00, 1, 1'b1, 0, 18};
        vecs[5] = '{1'b1, 8'h00, 8'h70, 8'd2, 8'h5A, 1, 1'b0, 2, -1};

        #1;
        check("rst busy", busy, 0);
        check("rst pulses", {finished, error, mem_start}, 3'b000);
        check("rst mem_op", mem_op, 2'b00);
        check("rst mem_addr", mem_addr, 0);
        check("rst mem_wdata", mem_wdata, 0);
        check("rst count", count, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        for (int v = 0; v < 6; v++)
            run_cmd($sformatf("vec%0d", v), vecs[v].mode, vecs[v].src, vecs[v].dst, vecs[v].len,
                    vecs[v].fill, vecs[v].lat, vecs[v].hang, vecs[v].exp_count, vecs[v].exp_delay);

        check("fill mem10..13", {mem[8'h10], mem[8'h11], mem[8'h12], mem[8'h13]}, 32'hA5A5A5A5);
        check("copy mem40..42", {mem[8'h40], mem[8'h41], mem[8'h42]}, 24'h112233);

        for (int t = 0; t < 24; t++) begin
            rm = 1'($urandom);
            rs = 8'($urandom);
            rd = 8'($urandom);
            rn = 8'($urandom_range(0, 10));
            rf = 8'($urandom);
            rl = int'($urandom_range(1, 4));
            rh = ($urandom_range(0, 7) == 0);
            run_cmd($sformatf("rnd%0d", t), rm, rs, rd, rn, rf, rl, rh,
                    (rh && rn != 0) ? 0 : int'(rn), -1);
        end

        // Reset during the second byte's read wait; the late response must not produce a write.
        @(negedge clk);
        saved = mem[8'h51];
        lat = 3; hang = 1'b0; log_q.delete(); fin_cnt = 0; err_cnt = 0;
        mode = 1'b0; src_base = 8'h30; dst_base = 8'h50; length = 8'd3; go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        w = 0;
        while (log_q.size() < 3 && w < 200) begin
            @(negedge clk);
            w++;
        end
        check("rstmid reached_rd1", (w < 200) ? 1 : 0, 1);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("rstmid ctl", {busy, finished, error, mem_start, mem_op}, 6'b0);
        check("rstmid addr", mem_addr, 0);
        check("rstmid wdata", mem_wdata, 0);
        check("rstmid count", count, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (8) @(negedge clk);
        check("rstmid nreq", log_q.size(), 3);
        check("rstmid dst1", mem[8'h51], saved);
        check("rstmid busy", busy, 0);
        check("rstmid pulses", fin_cnt + err_cnt, 0);

        check("no b2b start", viol_b2b, 0);
        check("no op 1x", viol_op, 0);
        check("addr/data hold", viol_hold, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_copy_initiator.md
Name: mem_copy_initiator

Overview:
- Initiator-side controller for the team's multicycle byte memory request interface (start/op/addr/write_data in; done/read_data out).
- Issues sequences of single-byte requests to perform a block copy (read source, write destination) or a block fill (write a constant).
- Sits between a host or control FSM and one multicycle memory instance.
- Owns request sequencing, address generation, data hand-off between read and write, and a response timeout.

Parameters:
- AW, 8, address width; addresses wrap modulo 2^AW.
- DW, 8, data width.
- TIMEOUT, 15, max cycles waiting for mem_done after a request before aborting; valid range 1..255.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- go  input  1  command strobe; sampled only in IDLE.
- mode  input  1  0 = copy, 1 = fill; captured with go.
- src_base  input  AW  copy source start address; captured with go.
- dst_base  input  AW  destination start address; captured with go.
- length  input  AW  byte count; captured with go; 0 = no transfer.
- fill_data  input  DW  fill constant; captured with go.
- busy  output  1  high from the cycle after go is accepted until return to IDLE.
- finished  output  1  one-cycle pulse on successful completion.
- error  output  1  one-cycle pulse on timeout abort.
- count  output  AW  bytes written so far in the current or last command.
- mem_start  output  1  request strobe to memory; always a one-cycle pulse.
- mem_op  output  2  2'b00 = write, 2'b01 = read; 2'b1x is never driven.
- mem_addr  output  AW  request address; held stable from the mem_start pulse until mem_done.
- mem_wdata  output  DW  write data; held stable with mem_addr.
- mem_done  input  1  memory completion pulse, one cycle.
- mem_rdata  input  DW  read data; valid in the cycle mem_done is high after a read.

Behaviour:
- Reset values (async, immediate):
  - state = IDLE.
  - busy, finished, error, mem_start = 0.
  - mem_op = 2'b00, mem_addr = 0, mem_wdata = 0, count = 0.
  - internal pointers, remaining count and timer = 0.
- States: IDLE, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT, STEP, FINISH, ABORT.
- IDLE:
  - finished and error are forced to 0.
  - On go=1, capture all command inputs and clear count.
  - length=0 goes to FINISH.
  - Otherwise mode=0 goes to RD_REQ and mode=1 goes to WR_REQ.
  - go is ignored in every other state; there is no queueing.
- RD_REQ: mem_start=1 for exactly this cycle, mem_op=01, mem_addr=src_ptr, timer=0 -> RD_WAIT.
- RD_WAIT:
  - mem_done=1: latch mem_rdata into the data register -> WR_REQ.
  - Otherwise timer increments; when timer reaches TIMEOUT -> ABORT.
- WR_REQ: mem_start=1 for exactly this cycle, mem_op=00, mem_addr=dst_ptr, mem_wdata = latched data (copy) or fill_data (fill), timer=0 -> WR_WAIT.
- WR_WAIT:
  - mem_done=1: count+1 -> STEP.
  - Timeout rule is the same as RD_WAIT.
- STEP:
  - src_ptr+1 and dst_ptr+1, wrapping mod 2^AW; remaining-1.
  - If remaining was 1 -> FINISH.
  - Else mode=0 -> RD_REQ, mode=1 -> WR_REQ.
- FINISH: finished=1 for one cycle -> IDLE.
- ABORT: error=1 for one cycle -> IDLE. count holds the number of completed writes. No further requests are issued.
- mem_start is never asserted in back-to-back cycles. At least one cycle always separates a mem_done from the next mem_start (the STEP state or the WR_REQ transition).
- A mem_done arriving in any state other than RD_WAIT or WR_WAIT is ignored.
- mem_done in the same cycle the timer reaches TIMEOUT: mem_done wins and there is no abort.
- Overlapping regions: data is moved strictly byte by byte in ascending address order. No overlap correction is applied.
- Reset mid-transfer returns everything to reset values immediately. A memory operation already in flight may still complete; its mem_done is then ignored in IDLE.
- busy = (state != IDLE).
- Per-byte cost is 2 requests (copy) or 1 request (fill), plus memory latency, plus one STEP cycle.

Test Plan:
- Fill: go, mode=1, dst_base=8'h10, length=4, fill_data=8'hA5 -> exactly 4 writes to 10..13, all with data A5, and no reads. finished pulses once, count=4, busy drops the cycle after finished.
- Copy: preload mem[20..22] = 11,22,33; go, mode=0, src=8'h20, dst=8'h40, length=3 -> read/write pairs in order. mem[40..42] = 11,22,33; finished=1, count=3.
- Wrap: copy src=8'hFE, dst=8'hFF, length=3 -> reads FE,FF,00 and writes FF,00,01, with no out-of-range addresses.
- Zero length: go with length=0 -> mem_start never asserted, finished pulses 2 cycles after go, count=0.
- Timeout: memory stub never asserts mem_done, TIMEOUT=15 -> error pulses after 15 wait cycles, count=0, mem_start pulsed exactly once. A second go is then accepted normally.
- Reset mid-copy: assert rst during the second byte's RD_WAIT -> all outputs return to 0 in the same cycle. The late mem_done is ignored, and no write reaches dst+1.
